polar_sc_sequencer: RTL and testbench

//  Successive-cancellation (SC) decode sequencer for one polar codeword of N LLRs.

---
 rtl/polar_sc_sequencer_if.sv | 42 ++++
 rtl/polar_sc_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_polar_sc_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/polar_sc_sequencer_if.sv
// Stream and status bundle for the polar SC decode sequencer.
// Optional perf counters appear when POLAR_SEQ_PERF_EN is defined.
interface polar_sc_sequencer_if #(
    parameter int N        = 8,
    parameter int QTF_SIZE = 8
);
    logic                       flush_i;
    logic [N-1:0]               frozen_i;
    logic                       llr_valid_i;
    logic                       llr_ready_o;
    logic signed [QTF_SIZE-1:0] llr_i;
    logic                       bits_valid_o;
    logic                       bits_ready_i;
    logic [N-1:0]               bits_o;
    logic                       busy_o;
`ifdef POLAR_SEQ_PERF_EN
    logic [31:0]                perf_words_o;
    logic [31:0]                perf_sat_o;

    modport slave (
        input  flush_i, frozen_i, llr_valid_i, llr_i, bits_ready_i,
        output llr_ready_o, bits_valid_o, bits_o, busy_o,
        output perf_words_o, perf_sat_o
    );

    modport master (
        output flush_i, frozen_i, llr_valid_i, llr_i, bits_ready_i,
        input  llr_ready_o, bits_valid_o, bits_o, busy_o,
        input  perf_words_o, perf_sat_o
    );
`else
    modport slave (
        input  flush_i, frozen_i, llr_valid_i, llr_i, bits_ready_i,
        output llr_ready_o, bits_valid_o, bits_o, busy_o
    );

    modport master (
        output flush_i, frozen_i, llr_valid_i, llr_i, bits_ready_i,
        input  llr_ready_o, bits_valid_o, bits_o, busy_o
    );
`endif
endinterface

// File: rtl/polar_sc_sequencer.sv
// Successive-cancellation polar decode sequencer, one F/G/R element per cycle.
// Define POLAR_SEQ_PERF_EN to add the word and g-saturation perf counters.
module polar_sc_sequencer #(
    parameter int N        = 8,
    parameter int QTF_SIZE = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    polar_sc_sequencer_if.slave io
);
    localparam int LW = $clog2(N);
    localparam int QW = QTF_SIZE;

    typedef logic signed [QW-1:0] llr_t;
    typedef logic signed [QW:0]   wide_t;

    localparam wide_t          QPOS    = wide_t'((1 << (QW - 1)) - 1);
    localparam wide_t          QNEG    = -QPOS;
    localparam llr_t           QMAX_L  = llr_t'(QPOS);
    localparam llr_t           QMIN_L  = -QMAX_L;
    localparam llr_t           LLR_MIN = {1'b1, {(QW-1){1'b0}}};
    localparam logic [LW-1:0]  ONE     = LW'(1);
    localparam logic [LW-1:0]  LAST    = LW'(N - 1);
    localparam logic [LW-1:0]  TOP     = LW'(LW);

    typedef enum logic [1:0] {
        S_LOAD,
        S_DECODE,
        S_OUT
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] cnt_q;
    logic [LW-1:0] leaf_q;
    logic [LW-1:0] lvl_q;
    logic [LW-1:0] elem_q;
    logic          is_leaf_q;
    logic          is_g_q;
    logic [N-1:0]  frozen_q;
    logic [N-1:0]  u_q;
    llr_t          mem_q [0:N-1][0:N-1];

    logic          accept;
    llr_t          llr_in;
    logic [LW-1:0] hs;
    logic [LW-1:0] lvl_up;
    logic [LW-1:0] idx_hi;
    logic [LW-1:0] vidx;
    logic [N-1:0]  enc;
    logic          vbit;
    llr_t          op_a, op_b;
    llr_t          abs_a, abs_b, mn;
    llr_t          f_res, g_res, res;
    wide_t         wa, wb, sum;
    logic          sat_hi, sat_lo;
    logic          last_elem;
    logic          leaf_bit;

    // Trailing-zero count: level of the right-child g pass for a new leaf.
    function automatic logic [LW-1:0] tz(input logic [LW-1:0] x);
        logic [LW-1:0] r;
        logic          found;
        r     = '0;
        found = 1'b0;
        for (int k = 0; k < LW; k++) begin
            if (!found && x[k]) begin
                r     = LW'(k);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Apply the first s butterfly stages to u; every aligned 2^s block
    // then holds the re-encoded bits of that subtree.
    function automatic logic [N-1:0] part_enc(
        input logic [N-1:0]  uin,
        input logic [LW-1:0] s
    );
        logic [N-1:0] p, nx;
        p = uin;
        for (int k = 0; k < LW - 1; k++) begin
            nx = p;
            if (LW'(k) < s) begin
                for (int b = 0; b < N; b++) begin
                    if (((b >> k) % 2) == 0) begin
                        nx[LW'(b)] = p[LW'(b)] ^ p[LW'(b) ^ (ONE << k)];
                    end
                end
            end
            p = nx;
        end
        return p;
    endfunction

    // Element datapath: operand fetch, f, g with saturation, leaf decision.
    always_comb begin
        accept    = (state_q == S_LOAD) && io.llr_valid_i;
        llr_in    = (io.llr_i == LLR_MIN) ? QMIN_L : io.llr_i;
        hs        = ONE << lvl_q;
        lvl_up    = lvl_q + ONE;
        idx_hi    = elem_q + hs;
        vidx      = leaf_q - hs + elem_q;
        enc       = part_enc(u_q, lvl_q);
        vbit      = enc[vidx];
        op_a      = mem_q[lvl_up][elem_q];
        op_b      = mem_q[lvl_up][idx_hi];
        abs_a     = op_a[QW-1] ? -op_a : op_a;
        abs_b     = op_b[QW-1] ? -op_b : op_b;
        mn        = (abs_a < abs_b) ? abs_a : abs_b;
        f_res     = (op_a[QW-1] ^ op_b[QW-1]) ? -mn : mn;
        wa        = {op_a[QW-1], op_a};
        wb        = {op_b[QW-1], op_b};
        sum       = vbit ? (wb - wa) : (wb + wa);
        sat_hi    = sum > QPOS;
        sat_lo    = sum < QNEG;
        g_res     = sat_hi ? QMAX_L : (sat_lo ? QMIN_L : llr_t'(sum));
        res       = is_g_q ? g_res : f_res;
        last_elem = (elem_q == (hs - ONE));
        leaf_bit  = mem_q[0][0][QW-1] & ~frozen_q[leaf_q];
    end

    // State register; reset wins over flush.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d         = state_q;
        io.llr_ready_o  = 1'b0;
        io.bits_valid_o = 1'b0;
        io.busy_o       = 1'b0;
        io.bits_o       = '0;
        unique case (state_q)
            S_LOAD: begin
                io.llr_ready_o = 1'b1;
                if (accept && (cnt_q == LAST)) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                io.busy_o = 1'b1;
                if (is_leaf_q && (leaf_q == LAST)) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                io.bits_valid_o = 1'b1;
                io.bits_o       = u_q;
                if (io.bits_ready_i) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
        if (io.flush_i) begin
            state_d = S_LOAD;
        end
    end

    // Schedule walker: leaf index, tree level, element index, op kind.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || io.flush_i) begin
            cnt_q     <= '0;
            leaf_q    <= '0;
            lvl_q     <= '0;
            elem_q    <= '0;
            is_leaf_q <= 1'b0;
            is_g_q    <= 1'b0;
            frozen_q  <= '0;
            u_q       <= '0;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    if (accept) begin
                        cnt_q <= cnt_q + ONE;
                        if (cnt_q == '0) begin
                            frozen_q <= io.frozen_i;
                        end
                        if (cnt_q == LAST) begin
                            leaf_q    <= '0;
                            lvl_q     <= LW'(LW - 1);
                            elem_q    <= '0;
                            is_leaf_q <= 1'b0;
                            is_g_q    <= 1'b0;
                            u_q       <= '0;
                        end
                    end
                end
                S_DECODE: begin
                    if (is_leaf_q) begin
                        u_q[leaf_q] <= leaf_bit;
                        if (leaf_q != LAST) begin
                            leaf_q    <= leaf_q + ONE;
                            lvl_q     <= tz(leaf_q + ONE);
                            elem_q    <= '0;
                            is_leaf_q <= 1'b0;
                            is_g_q    <= 1'b1;
                        end
                    end else if (last_elem) begin
                        elem_q <= '0;
                        if (lvl_q == '0) begin
                            is_leaf_q <= 1'b1;
                        end else begin
                            lvl_q  <= lvl_q - ONE;
                            is_g_q <= 1'b0;
                        end
                    end else begin
                        elem_q <= elem_q + ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // LLR storage: channel row loaded in LOAD, tree rows written in DECODE.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !io.flush_i) begin
            if (accept) begin
                mem_q[TOP][cnt_q] <= llr_in;
            end
            if ((state_q == S_DECODE) && !is_leaf_q) begin
                mem_q[lvl_q][elem_q] <= res;
            end
        end
    end

`ifdef POLAR_SEQ_PERF_EN
    logic [31:0] perf_words_q;
    logic [31:0] perf_sat_q;

    // Perf counters survive flush; only reset clears them.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            perf_words_q <= '0;
            perf_sat_q   <= '0;
        end else if (!io.flush_i) begin
            if ((state_q == S_OUT) && io.bits_ready_i) begin
                perf_words_q <= perf_words_q + 32'd1;
            end
            if ((state_q == S_DECODE) && !is_leaf_q && is_g_q &&
                (sat_hi || sat_lo)) begin
                perf_sat_q <= perf_sat_q + 32'd1;
            end
        end
    end

    assign io.perf_words_o = perf_words_q;
    assign io.perf_sat_o   = perf_sat_q;
`endif
endmodule

// File: tb/tb_polar_sc_sequencer.sv
// Directed scoreboard bench for polar_sc_sequencer at N=4, 8-bit LLRs.
// Expected words are derived by hand from the SC recursion.
module tb_polar_sc_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc;
    logic [3:0] exp_q[$];
    logic [3:0] held;
`ifdef POLAR_SEQ_PERF_EN
    logic [31:0] p0;
`endif

    polar_sc_sequencer_if #(.N(4), .QTF_SIZE(8)) io ();

    polar_sc_sequencer #(.N(4), .QTF_SIZE(8)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .io    (io.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [7:0] a, b, c, d,
                        input logic [3:0] frz, input logic [3:0] expb,
                        input bit push);
        logic signed [7:0] w [4];
        w = '{a, b, c, d};
        if (push) exp_q.push_back(expb);
        for (int k = 0; k < 4; k++) begin
            io.llr_valid_i = 1'b1;
            io.llr_i       = w[k];
            io.frozen_i    = (k == 0) ? frz : ~frz;
            tick();
        end
        io.llr_valid_i = 1'b0;
        io.llr_i       = 8'sh55;
    endtask

    task automatic wait_out(output int c);
        c = 0;
        while (io.bits_valid_o !== 1'b1 && c < 200) begin
            tick();
            c++;
        end
    endtask

    task automatic recv(input string tag, output int c);
        logic [3:0] e;
        wait_out(c);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bx;
        chk({tag, "_bits"}, 32'(io.bits_o), 32'(e));
        chk({tag, "_rdy_out"}, 32'(io.llr_ready_o), 32'd0);
        io.bits_ready_i = 1'b1;
        tick();
        io.bits_ready_i = 1'b0;
        chk({tag, "_vld_after"}, 32'(io.bits_valid_o), 32'd0);
        chk({tag, "_rdy_after"}, 32'(io.llr_ready_o), 32'd1);
    endtask

    initial begin
        rst_n           = 1'b0;
        io.flush_i      = 1'b0;
        io.frozen_i     = '0;
        io.llr_valid_i  = 1'b0;
        io.llr_i        = '0;
        io.bits_ready_i = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(io.llr_ready_o), 32'd1);
        chk("rst_valid", 32'(io.bits_valid_o), 32'd0);
        chk("rst_bits", 32'(io.bits_o), 32'd0);
        chk("rst_busy", 32'(io.busy_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // all +10: all zeros, 12 decode cycles
        send(10, 10, 10, 10, 4'b0000, 4'b0000, 1);
        chk("t1_busy", 32'(io.busy_o), 32'd1);
        chk("t1_rdy_dec", 32'(io.llr_ready_o), 32'd0);
        recv("t1", cyc);
        chk("t1_latency", 32'(cyc), 32'd12);

        send(-20, -20, -20, -20, 4'b0000, 4'b1000, 1);
        recv("t2", cyc);

`ifdef POLAR_SEQ_PERF_EN
        p0 = io.perf_sat_o;
`endif
        send(-100, -100, -100, -100, 4'b0000, 4'b1000, 1);
        recv("t3", cyc);
`ifdef POLAR_SEQ_PERF_EN
        chk("t3_perf_sat", io.perf_sat_o - p0, 32'd4);
        chk("t3_perf_words", io.perf_words_o, 32'd3);
`endif

        send(-20, -20, -20, -20, 4'b1000, 4'b0000, 1);
        recv("t4", cyc);
        send(-128, -128, -128, -128, 4'b1000, 4'b0000, 1);
        recv("t4_clamp", cyc);
        send(-128, 5, 5, 5, 4'b0000, 4'b0001, 1);
        recv("t4_mix", cyc);

        send(10, 10, 10, -30, 4'b0000, 4'b1111, 1);
        recv("p_1111", cyc);
        send(-30, 10, 10, 10, 4'b0000, 4'b0001, 1);
        recv("p_0001", cyc);
        send(-30, 10, 10, 10, 4'b0001, 4'b0100, 1);
        recv("p_frz", cyc);

        // flush mid-LOAD drops the partial word
        io.llr_valid_i = 1'b1;
        io.llr_i       = -100;
        tick();
        tick();
        io.llr_valid_i = 1'b0;
        io.flush_i     = 1'b1;
        tick();
        io.flush_i = 1'b0;
        send(10, 10, 10, 10, 4'b0000, 4'b0000, 1);
        recv("fl_load", cyc);

        // flush at decode cycle 5
        send(-20, -20, -20, -20, 4'b0000, 4'b1000, 0);
        repeat (4) tick();
        chk("fl_dec_busy_pre", 32'(io.busy_o), 32'd1);
        io.flush_i = 1'b1;
        tick();
        io.flush_i = 1'b0;
        chk("fl_dec_busy", 32'(io.busy_o), 32'd0);
        chk("fl_dec_rdy", 32'(io.llr_ready_o), 32'd1);
        chk("fl_dec_vld", 32'(io.bits_valid_o), 32'd0);
        send(10, 10, 10, 10, 4'b0000, 4'b0000, 1);
        recv("fl_dec", cyc);
        repeat (15) tick();
        chk("fl_dec_nostale", 32'(io.bits_valid_o), 32'd0);

        // flush in OUT drops the word
        send(-20, -20, -20, -20, 4'b0000, 4'b1000, 0);
        wait_out(cyc);
        chk("fl_out_vld_pre", 32'(io.bits_valid_o), 32'd1);
        io.flush_i = 1'b1;
        tick();
        io.flush_i = 1'b0;
        chk("fl_out_vld", 32'(io.bits_valid_o), 32'd0);
        chk("fl_out_rdy", 32'(io.llr_ready_o), 32'd1);

        // hold OUT for 10 cycles with stray LLR traffic, then reset
        send(-20, -20, -20, -20, 4'b0000, 4'b1000, 1);
        wait_out(cyc);
        held = exp_q[0];
        for (int k = 0; k < 10; k++) begin
            io.llr_valid_i = 1'b1;
            io.llr_i       = 8'($urandom_range(0, 255));
            tick();
            chk("hold_bits", 32'(io.bits_o), 32'(held));
            chk("hold_rdy", 32'(io.llr_ready_o), 32'd0);
        end
        io.llr_valid_i = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        void'(exp_q.pop_front());
        chk("rst2_ready", 32'(io.llr_ready_o), 32'd1);
        chk("rst2_valid", 32'(io.bits_valid_o), 32'd0);
        chk("rst2_bits", 32'(io.bits_o), 32'd0);
        chk("rst2_busy", 32'(io.busy_o), 32'd0);
`ifdef POLAR_SEQ_PERF_EN
        chk("rst2_perf_words", io.perf_words_o, 32'd0);
        chk("rst2_perf_sat", io.perf_sat_o, 32'd0);
`endif
        send(-30, 10, 10, 10, 4'b0000, 4'b0001, 1);
        recv("post_rst", cyc);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
